// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte buffer behind uart_rx, keeping parity/frame flags per byte.
// Optional build macro UART_RX_FIFO_ERR_DROP_EN: errored bytes are counted but not stored.
module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    input  logic [7:0]              rx_data,
    input  logic                    parity_err,
    input  logic                    frame_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_data,
    output logic                    out_parity_err,
    output logic                    out_frame_err,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full,
    output logic [15:0]             err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(AF_THRESH);

    typedef struct packed {
        logic       frame_err;
        logic       parity_err;
        logic [7:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;
    logic          push_hs;
    logic          rx_err;
    logic          do_write;
    logic          do_pop;

    // Handshake readiness comes only from registered flags, so there is no input-to-output path.
    assign rx_ready  = ~full;
    assign out_valid = ~empty;
    assign push_hs   = rx_valid & rx_ready;
    assign rx_err    = parity_err | frame_err;
    assign do_pop    = out_valid & out_ready;
    assign head      = mem[rd_ptr];
    assign out_data  = head.data;

`ifdef UART_RX_FIFO_ERR_DROP_EN
    assign do_write       = push_hs & ~rx_err;
    assign out_parity_err = 1'b0;
    assign out_frame_err  = 1'b0;
`else
    assign do_write       = push_hs;
    assign out_parity_err = head.parity_err;
    assign out_frame_err  = head.frame_err;
`endif

    always_comb begin
        level_nxt = level + LW'(do_write) - LW'(do_pop);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
            level       <= level_nxt;
            empty       <= (level_nxt == '0);
            full        <= (level_nxt == LVL_FULL);
            almost_full <= (level_nxt >= LVL_AF);
        end
    end

    // NOTE: payload RAM has no reset; stale words are never visible because out_valid gates them.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= '{frame_err: frame_err, parity_err: parity_err, data: rx_data};
        end
    end

    // Errors are counted on every accepted byte, including during flush and when the byte is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (push_hs && rx_err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table plus scoreboard on a 16-deep instance,
// hand-written full/back-pressure sequence on a 4-deep instance.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int DEPTH     = 16;
    localparam int AF_THRESH = 12;
`ifdef UART_RX_FIFO_ERR_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, flush, rx_valid, parity_err, frame_err, out_ready;
    logic [7:0]  rx_data;
    logic        rx_ready, out_valid, out_parity_err, out_frame_err;
    logic [7:0]  out_data;
    logic [4:0]  level;
    logic        empty, full, almost_full;
    logic [15:0] err_count;

    logic        s_flush, s_rx_valid, s_out_ready;
    logic [7:0]  s_rx_data;
    logic        s_rx_ready, s_out_valid, s_out_parity_err, s_out_frame_err;
    logic [7:0]  s_out_data;
    logic [2:0]  s_level;
    logic        s_empty, s_full, s_almost_full;
    logic [15:0] s_err_count;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .parity_err(parity_err), .frame_err(frame_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_parity_err(out_parity_err), .out_frame_err(out_frame_err),
        .level(level), .empty(empty), .full(full), .almost_full(almost_full),
        .err_count(err_count)
    );

    uart_rx_fifo #(.DEPTH(4), .AF_THRESH(3)) u_small (
        .clk(clk), .reset(reset), .flush(s_flush),
        .rx_valid(s_rx_valid), .rx_ready(s_rx_ready), .rx_data(s_rx_data),
        .parity_err(1'b0), .frame_err(1'b0),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_parity_err(s_out_parity_err), .out_frame_err(s_out_frame_err),
        .level(s_level), .empty(s_empty), .full(s_full), .almost_full(s_almost_full),
        .err_count(s_err_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard entries are {frame_err, parity_err, data}.
    logic [9:0]  sb[$];
    int unsigned m_err = 0;

    task automatic drive(input logic rv, input logic [7:0] d, input logic pe, input logic fe,
                         input logic ordy, input logic fl);
        rx_valid   = rv;
        rx_data    = d;
        parity_err = pe;
        frame_err  = fe;
        out_ready  = ordy;
        flush      = fl;
    endtask

    // One clock on the main instance: check pre-edge outputs, advance the model, check registered state.
    task automatic step();
        bit         exp_push, exp_pop, err;
        logic [9:0] head;
        exp_push = rx_valid && (sb.size() < DEPTH);
        exp_pop  = out_ready && (sb.size() != 0);
        err      = parity_err | frame_err;
        check("rx_ready", rx_ready, sb.size() < DEPTH);
        check("out_valid", out_valid, sb.size() != 0);
        if (sb.size() != 0) begin
            head = sb[0];
            check("out_data", out_data, head[7:0]);
            check("out_parity_err", out_parity_err, head[8]);
            check("out_frame_err", out_frame_err, head[9]);
        end
        @(posedge clk);
        if (reset) begin
            sb.delete();
            m_err = 0;
        end else begin
            if (exp_push && err && m_err != 32'hFFFF) m_err++;
            if (flush) begin
                sb.delete();
            end else begin
                if (exp_pop) void'(sb.pop_front());
                if (exp_push && !(DROP && err)) sb.push_back({frame_err, parity_err, rx_data});
            end
        end
        @(negedge clk);
        check("level", level, sb.size());
        check("empty", empty, sb.size() == 0);
        check("full", full, sb.size() == DEPTH);
        check("almost_full", almost_full, sb.size() >= AF_THRESH);
        check("err_count", err_count, m_err);
    endtask

    typedef struct {
        logic       rv;
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       ordy;
        logic       fl;
        int         exp_level;
    } vec_t;

    vec_t vt[16];

    initial begin
        vt[0]  = '{1'b1, 8'h48, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vt[1]  = '{1'b1, 8'h45, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vt[2]  = '{1'b1, 8'h4C, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vt[3]  = '{1'b1, 8'h4C, 1'b0, 1'b0, 1'b0, 1'b0, 4};
        vt[4]  = '{1'b1, 8'h4F, 1'b0, 1'b0, 1'b0, 1'b0, 5};
        vt[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5};
        vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4};
        vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3};
        vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vt[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vt[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vt[12] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vt[13] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vt[14] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        vt[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2};

        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        s_flush = 1'b0; s_rx_valid = 1'b0; s_rx_data = 8'h00; s_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_almost_full", almost_full, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_rx_ready", rx_ready, 1);
        check("rst_err_count", err_count, 0);
        reset = 1'b0;

        // 4-deep instance: almost_full, full, back-pressure and release after one pop.
        for (int i = 0; i < 4; i++) begin
            s_rx_valid = 1'b1;
            s_rx_data  = 8'hB0 + 8'(i);
            @(posedge clk); @(negedge clk);
            check("s_level_fill", s_level, i + 1);
            check("s_almost_full", s_almost_full, (i + 1) >= 3);
            check("s_full", s_full, i == 3);
        end
        s_rx_data = 8'hE5;
        check("s_rx_ready_full", s_rx_ready, 0);
        @(posedge clk); @(negedge clk);
        check("s_level_held", s_level, 4);
        check("s_head", s_out_data, 8'hB0);
        s_out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        s_out_ready = 1'b0;
        check("s_level_pop", s_level, 3);
        check("s_rx_ready_release", s_rx_ready, 1);
        @(posedge clk); @(negedge clk);
        s_rx_valid = 1'b0;
        check("s_level_refill", s_level, 4);
        check("s_full_again", s_full, 1);
        s_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp_b;
            exp_b = (i == 3) ? 8'hE5 : 8'hB1 + 8'(i);
            check("s_drain_valid", s_out_valid, 1);
            check("s_drain_data", s_out_data, exp_b);
            @(posedge clk); @(negedge clk);
        end
        s_out_ready = 1'b0;
        check("s_empty", s_empty, 1);
        check("s_level_end", s_level, 0);

        // Main instance: HELLO push/drain and a simultaneous push/pop from the vector table.
        for (int i = 0; i < 16; i++) begin
            drive(vt[i].rv, vt[i].d, vt[i].pe, vt[i].fe, vt[i].ordy, vt[i].fl);
            step();
            check("vec_level", level, vt[i].exp_level);
        end

        // Streaming at level 2 wraps both pointers several times.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1, 1'b0);
            step();
            check("wrap_level", level, 2);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) step();
        check("wrap_empty", empty, 1);

        // Errored bytes.
        drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("err_count_first", err_count, 1);
        check("err_level", level, DROP ? 0 : 1);
        drive(1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("err_count_second", err_count, 2);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) step();

        // Flush with a concurrent errored handshake, then with a clean one.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        check("flush_level", level, 0);
        check("flush_err_count", err_count, 3);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("flush_out_valid", out_valid, 0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        check("flush2_empty", empty, 1);
        check("flush2_err_count", err_count, 3);
        drive(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("post_flush_level", level, 1);

        // Reset mid-operation while popping.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        check("pre_reset_level", level, 5);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_level", level, 0);
        check("reset_err_count", err_count, 0);
        check("reset_rx_ready", rx_ready, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
